// File: rtl/reg_file_pkg.sv
// Shared defaults and port-slice helpers for the register file with write scoreboard.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned ZERO_IDX       = 0;

    // Low bit of port p inside a flattened multi-port bus
    function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_sb_busy.sv
// Scoreboard busy vector: reserve/release/flush priority and registered busy popcount.
module reg_sb_busy
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic                      rsv_en,
    input  logic [ADDR_WIDTH-1:0]     rsv_addr,
    input  logic                      flush,
    output logic                      rsv_ok,
    output logic [(2**ADDR_WIDTH)-1:0] busy,
    output logic [ADDR_WIDTH:0]       busy_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_WIDTH:0] r_cnt;
    logic              w_rsv_zero;
    logic              w_wr_zero;
    logic              w_set;
    logic              w_clr;
    logic              w_inc;
    logic              w_dec;
    logic [DEPTH-1:0]  w_busy_nxt;

    assign w_rsv_zero = ZERO_REG && (rsv_addr == ADDR_WIDTH'(ZERO_IDX));
    assign w_wr_zero  = ZERO_REG && (wr_addr == ADDR_WIDTH'(ZERO_IDX));

    // A busy bit released by this cycle's write counts as free for reservation
    always_comb begin
        rsv_ok = 1'b0;
        if (rsv_en) begin
            if (w_rsv_zero)
                rsv_ok = 1'b1;
            else
                rsv_ok = !r_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr));
        end
    end

    assign w_set = rsv_ok && !w_rsv_zero && !flush;
    assign w_clr = wr_en && !w_wr_zero;
    assign w_inc = w_set && !r_busy[rsv_addr];
    assign w_dec = w_clr && r_busy[wr_addr] && !(w_set && (wr_addr == rsv_addr));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr)
            w_busy_nxt[wr_addr] = 1'b0;
        if (w_set)
            w_busy_nxt[rsv_addr] = 1'b1;
        if (flush)
            w_busy_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (flush)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + {{ADDR_WIDTH{1'b0}}, w_inc} - {{ADDR_WIDTH{1'b0}}, w_dec};
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with zero register, write->read bypass and RAW scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = 2,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_sel,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           rsv_en,
    input  logic [ADDR_WIDTH-1:0]          rsv_addr,
    output logic                           rsv_ok,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            busy_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      w_busy;
    logic                  w_wr_live;

    assign w_wr_live = wr_en && !(ZERO_REG && (wr_addr == ADDR_WIDTH'(ZERO_IDX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_live) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    reg_sb_busy #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rsv_ok   (rsv_ok),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_sel;
        logic                  w_zero;
        logic                  w_hit;

        assign w_sel  = rd_sel[port_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
        assign w_zero = ZERO_REG && (w_sel == ADDR_WIDTH'(ZERO_IDX));
        assign w_hit  = BYPASS && w_wr_live && (wr_addr == w_sel);

        always_comb begin
            rd_data[port_lo(p, DATA_WIDTH) +: DATA_WIDTH] = r_mem[w_sel];
            rd_busy[p]                                     = w_busy[w_sel];
            if (w_zero) begin
                rd_data[port_lo(p, DATA_WIDTH) +: DATA_WIDTH] = '0;
                rd_busy[p]                                     = 1'b0;
            end else if (w_hit) begin
                rd_data[port_lo(p, DATA_WIDTH) +: DATA_WIDTH] = wr_data;
                rd_busy[p]                                     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass and non-bypass instances share one stimulus stream.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_sel;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ok, rsv_ok_nb;
    logic        flush;
    logic [5:0]  busy_cnt, busy_cnt_nb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .flush(flush), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_nb), .flush(flush), .busy_cnt(busy_cnt_nb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [9:0] sel(input logic [4:0] p0, input logic [4:0] p1);
        return {p1, p0};
    endfunction

    initial begin
        rst_n = 1'b0; idle(); wr_addr = '0; wr_data = '0; rsv_addr = '0;
        rd_sel = sel(5'd5, 5'd7);
        #1;
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_busy_cnt", busy_cnt, 6'd0);
        chk("reset_rd_busy", rd_busy, 2'b00);
        #1 rst_n = 1'b1;
        tick();

        // Write r5 with same-cycle read
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_sel = sel(5'd5, 5'd7);
        #1;
        chk("bypass_rd", rd_data[31:0], 32'hDEADBEEF);
        chk("nobypass_rd", rd_data_nb[31:0], 32'h0);
        tick(); idle();
        #1;
        chk("after_wr_rd", rd_data[31:0], 32'hDEADBEEF);
        chk("after_wr_rd_nb", rd_data_nb[31:0], 32'hDEADBEEF);

        // Reserve r7, retry, then release with write
        rsv_en = 1'b1; rsv_addr = 5'd7;
        #1;
        chk("rsv7_ok", rsv_ok, 1'b1);
        tick();
        #1;
        chk("rsv7_cnt", busy_cnt, 6'd1);
        chk("rsv7_rd_busy", rd_busy[1], 1'b1);
        chk("rsv7_again_ok", rsv_ok, 1'b0);
        rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        #1;
        chk("wr7_bypass_busy", rd_busy[1], 1'b0);
        chk("wr7_nobypass_busy", rd_busy_nb[1], 1'b1);
        chk("wr7_bypass_data", rd_data[63:32], 32'h11);
        tick(); idle();
        #1;
        chk("wr7_cnt", busy_cnt, 6'd0);
        chk("wr7_rd_busy", rd_busy[1], 1'b0);
        chk("wr7_data_nb", rd_data_nb[63:32], 32'h11);

        // Same-cycle write and reserve on busy r9
        rsv_en = 1'b1; rsv_addr = 5'd9; rd_sel = sel(5'd9, 5'd31);
        tick();
        #1;
        chk("rsv9_cnt", busy_cnt, 6'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        #1;
        chk("wr_rsv9_ok", rsv_ok, 1'b1);
        tick(); idle();
        #1;
        chk("wr_rsv9_cnt", busy_cnt, 6'd1);
        chk("wr_rsv9_busy", rd_busy[0], 1'b1);
        chk("wr_rsv9_data", rd_data[31:0], 32'h99);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
        tick(); idle();
        #1;
        chk("rel9_cnt", busy_cnt, 6'd0);

        // Top index: reserve r31, then write it free
        rsv_en = 1'b1; rsv_addr = 5'd31;
        tick(); idle();
        #1;
        chk("rsv31_busy", rd_busy[1], 1'b1);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5A5A5;
        tick(); idle();
        #1;
        chk("wr31_data", rd_data[63:32], 32'hA5A5A5A5);
        chk("wr31_cnt", busy_cnt, 6'd0);

        // Zero register
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0; rd_sel = sel(5'd0, 5'd0);
        #1;
        chk("zero_rd_bypass", rd_data[31:0], 32'h0);
        chk("zero_rsv_ok", rsv_ok, 1'b1);
        chk("zero_rd_busy", rd_busy, 2'b00);
        tick(); idle();
        #1;
        chk("zero_rd_after", rd_data_nb[31:0], 32'h0);
        chk("zero_cnt", busy_cnt, 6'd0);

        // Reserve r1..r3, then flush against a reserve of r4 and a write to r6
        for (int i = 1; i <= 3; i++) begin
            rsv_en = 1'b1; rsv_addr = 5'(i);
            tick();
        end
        idle();
        #1;
        chk("rsv123_cnt", busy_cnt, 6'd3);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        tick(); idle();
        rd_sel = sel(5'd4, 5'd3);
        #1;
        chk("flush_cnt", busy_cnt, 6'd0);
        chk("flush_rd_busy", rd_busy, 2'b00);
        rd_sel = sel(5'd1, 5'd6);
        #1;
        chk("flush_r1_busy", rd_busy[0], 1'b0);
        chk("flush_wr_data", rd_data[63:32], 32'h66);

        // Mid-run reset with a pending reservation
        rsv_en = 1'b1; rsv_addr = 5'd10;
        tick(); idle();
        #1;
        chk("pre_rst_cnt", busy_cnt, 6'd1);
        rd_sel = sel(5'd5, 5'd10);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_busy", rd_busy, 2'b00);
        chk("rst_cnt", busy_cnt, 6'd0);
        chk("rst_cnt_nb", busy_cnt_nb, 6'd0);
        rst_n = 1'b1;
        tick();
        #1;
        chk("post_rst_rd", rd_data_nb, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
